pll_cen_sequencer: RTL and testbench

- Multi-channel fractional clock-enable generator with lock-qualified reset sequencing.
- Sits directly behind the core PLL on one of its output clocks. It replaces ad-hoc divider logic for derived core rates (CPU, sound, video cen).
- Waits for a filtered, stable PLL lock. It then releases a core reset and produces NUM_CH independent cen pulse trains, each at rate inc/mod of the clock.
- Loss of lock re-asserts reset and silences every channel.

---
 rtl/pll_cen_sequencer_if.sv | 28 ++
 rtl/pll_cen_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_cen_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_cen_sequencer_if.sv
// Control/status bundle between the PLL clock-enable sequencer and its user.
// Ports: pll_locked, ch_en, inc, modulus, sync_restart, clr_flags (to DUT);
//        cen, rst_out, locked, lock_lost (from DUT).
interface pll_cen_sequencer_if #(
   parameter int NUM_CH = 4,
   parameter int ACC_W  = 16
);
   logic                      pll_locked;
   logic [NUM_CH-1:0]         ch_en;
   logic [NUM_CH*ACC_W-1:0]   inc;
   logic [NUM_CH*ACC_W-1:0]   modulus;
   logic                      sync_restart;
   logic                      clr_flags;
   logic [NUM_CH-1:0]         cen;
   logic                      rst_out;
   logic                      locked;
   logic                      lock_lost;

   modport master (
      output pll_locked, ch_en, inc, modulus, sync_restart, clr_flags,
      input  cen, rst_out, locked, lock_lost
   );

   modport slave (
      input  pll_locked, ch_en, inc, modulus, sync_restart, clr_flags,
      output cen, rst_out, locked, lock_lost
   );
endinterface

// File: rtl/pll_cen_sequencer.sv
// Lock-qualified core reset sequencer with NUM_CH fractional cen channels.
// Ports: refclk, rst (async, active high), bus (slave side of the bundle).
module pll_cen_sequencer #(
   parameter int NUM_CH     = 4,
   parameter int ACC_W      = 16,
   parameter int SETTLE_CYC = 1024
) (
   input  logic               refclk,
   input  logic               rst,
   pll_cen_sequencer_if.slave bus
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             sync1, lk_s;
   logic             rst_out_q, locked_q, lock_lost_q;
   logic             lost_set;
   logic             run_go;

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         lk_s  <= 1'b0;
      end else begin
         sync1 <= bus.pll_locked;
         lk_s  <= sync1;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (lk_s) begin
               cnt_nx   = CNT_LOAD;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (!lk_s)
               state_nx = IDLE;
            else if (cnt == '0)
               state_nx = RUN;
            else
               cnt_nx = cnt - 1'b1;
         end
         RUN: begin
            if (!lk_s)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign lost_set = (state == RUN) && !lk_s;

   // Channels only advance while RUN persists through this edge, so the
   // edge that leaves RUN already silences every cen.
   assign run_go = (state == RUN) && lk_s;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         rst_out_q   <= 1'b1;
         locked_q    <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         rst_out_q <= (state_nx != RUN);
         locked_q  <= (state_nx == RUN);
         if (lost_set)
            lock_lost_q <= 1'b1;
         else if (bus.clr_flags)
            lock_lost_q <= 1'b0;
      end
   end

   assign bus.rst_out   = rst_out_q;
   assign bus.locked    = locked_q;
   assign bus.lock_lost = lock_lost_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [ACC_W-1:0] inc_i, mod_i, inc_e, acc;
      logic [ACC_W:0]   sum, mod_x;
      logic             cen_q, hold;

      assign inc_i = bus.inc[g*ACC_W +: ACC_W];
      assign mod_i = bus.modulus[g*ACC_W +: ACC_W];
      assign inc_e = (inc_i > mod_i) ? mod_i : inc_i;
      assign sum   = {1'b0, acc} + {1'b0, inc_e};
      assign mod_x = {1'b0, mod_i};
      assign hold  = !run_go || !bus.ch_en[g] ||
                     (mod_i == '0) || bus.sync_restart;

      always_ff @(posedge refclk or posedge rst) begin
         if (rst) begin
            acc   <= '0;
            cen_q <= 1'b0;
         end else if (hold) begin
            acc   <= '0;
            cen_q <= 1'b0;
         end else if (acc >= mod_i) begin
            // Modulus dropped below the phase: resync with one pulse.
            acc   <= '0;
            cen_q <= 1'b1;
         end else if (sum >= mod_x) begin
            acc   <= ACC_W'(sum - mod_x);
            cen_q <= 1'b1;
         end else begin
            acc   <= sum[ACC_W-1:0];
            cen_q <= 1'b0;
         end
      end

      assign bus.cen[g] = cen_q;
   end

endmodule

// File: tb/tb_pll_cen_sequencer.sv
// Self-checking bench for pll_cen_sequencer: lock sequencing, cen rates,
// modulus recovery, phase restart, lock loss and async reset.
module tb_pll_cen_sequencer;

   localparam int N = 4;
   localparam int W = 16;
   localparam int S = 16;

   logic refclk = 1'b0;
   logic rst    = 1'b1;

   pll_cen_sequencer_if #(.NUM_CH(N), .ACC_W(W)) bus ();

   pll_cen_sequencer #(
      .NUM_CH(N), .ACC_W(W), .SETTLE_CYC(S)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus.slave)
   );

   always #5 refclk = ~refclk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: RUN is reached once the synchronized lock has been
   // seen high for SETTLE_CYC+1 consecutive edges (1 to leave IDLE plus
   // SETTLE_CYC settle edges), and any low sample drops out at once.
   bit       m_q1 = 0, m_q2 = 0;
   int       streak = 0;
   bit       m_run = 0, m_lost = 0;
   int       m_acc [N];
   bit [N-1:0] m_cen = '0;
   bit       m_lk, m_was, m_act;
   int       iv, mv, ie;

   initial for (int c = 0; c < N; c++) m_acc[c] = 0;

   always @(posedge refclk or posedge rst) begin
      if (rst) begin
         m_q1 = 0; m_q2 = 0; streak = 0;
         m_run = 0; m_lost = 0; m_cen = '0;
         for (int c = 0; c < N; c++) m_acc[c] = 0;
      end else begin
         m_lk  = m_q2;
         m_q2  = m_q1;
         m_q1  = bus.pll_locked;
         m_was = m_run;
         streak = m_lk ? streak + 1 : 0;
         m_run = (streak >= S + 1);
         if (m_was && !m_run) m_lost = 1;
         else if (bus.clr_flags) m_lost = 0;
         m_act = m_was && m_run;
         for (int c = 0; c < N; c++) begin
            iv = int'(bus.inc[c*W +: W]);
            mv = int'(bus.modulus[c*W +: W]);
            ie = (iv < mv) ? iv : mv;
            if (!m_act || !bus.ch_en[c] || mv == 0 || bus.sync_restart) begin
               m_acc[c] = 0; m_cen[c] = 0;
            end else if (m_acc[c] >= mv) begin
               m_acc[c] = 0; m_cen[c] = 1;
            end else if (m_acc[c] + ie >= mv) begin
               m_acc[c] = m_acc[c] + ie - mv; m_cen[c] = 1;
            end else begin
               m_acc[c] = m_acc[c] + ie; m_cen[c] = 0;
            end
         end
      end
   end

   always @(negedge refclk) begin
      chk("model_cen", int'(bus.cen), int'(m_cen));
      chk("model_rst_out", int'(bus.rst_out), int'(!m_run));
      chk("model_locked", int'(bus.locked), int'(m_run));
      chk("model_lock_lost", int'(bus.lock_lost), int'(m_lost));
   end

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic set_ch(input int c, input int i, input int m);
      bus.inc[c*W +: W]     = W'(i);
      bus.modulus[c*W +: W] = W'(m);
   endtask

   // Counts edges until locked rises; 0 means the bound expired.
   task automatic wait_lock(output int n);
      n = 0;
      while (!bus.locked && n < 200) begin
         tick();
         n++;
      end
      if (!bus.locked) begin
         $display("FAIL wait_lock actual=timeout required=locked");
         failures++;
         n = 0;
      end
   endtask

   int n, p0, p1, mm;
   logic [14:0] cap [N];

   initial begin
      bus.pll_locked   = 1'b0;
      bus.ch_en        = '0;
      bus.inc          = '0;
      bus.modulus      = '0;
      bus.sync_restart = 1'b0;
      bus.clr_flags    = 1'b0;
      tick(); tick(); tick();
      chk("rst_cen", int'(bus.cen), 0);
      chk("rst_rst_out", int'(bus.rst_out), 1);
      chk("rst_locked", int'(bus.locked), 0);
      chk("rst_lock_lost", int'(bus.lock_lost), 0);
      rst = 1'b0;
      set_ch(0, 1, 3);
      set_ch(1, 2, 5);
      set_ch(2, 7, 7);
      set_ch(3, 0, 4);
      bus.ch_en = 4'hF;
      tick(); tick();

      // Lock, then drop during SETTLE at count 8.
      bus.pll_locked = 1'b1;
      repeat (10) tick();
      bus.pll_locked = 1'b0;
      repeat (5) tick();
      chk("abort_rst_out", int'(bus.rst_out), 1);
      chk("abort_locked", int'(bus.locked), 0);

      // Full settle from rise of pll_locked to rst_out falling.
      bus.pll_locked = 1'b1;
      n = 0;
      while (bus.rst_out && n < 200) begin
         tick();
         n++;
      end
      chk("lock_edges", n, 19);
      chk("lock_locked", int'(bus.locked), 1);

      for (int k = 0; k < 15; k++) begin
         tick();
         for (int c = 0; c < N; c++) cap[c][k] = bus.cen[c];
      end
      chk("pat_ch0", int'(cap[0]), 'h4924);
      chk("pat_ch1", int'(cap[1]), 'h5294);
      chk("pat_ch2", int'(cap[2]), 'h7fff);
      chk("pat_ch3", int'(cap[3]), 0);

      // Let ch0 climb near 90 of 100, then shrink modulus to 10.
      set_ch(0, 1, 100);
      p0 = 0;
      repeat (88) begin
         tick();
         p0 += int'(bus.cen[0]);
      end
      chk("slow_ch0_pulses", p0, 0);
      set_ch(0, 1, 10);
      tick();
      chk("recover_pulse", int'(bus.cen[0]), 1);
      p0 = 0;
      repeat (9) begin
         tick();
         p0 += int'(bus.cen[0]);
      end
      chk("recover_gap", p0, 0);
      tick();
      chk("recover_next", int'(bus.cen[0]), 1);

      // Phase restart aligns equal channels.
      set_ch(0, 3, 7);
      set_ch(1, 3, 7);
      repeat (3) tick();
      bus.sync_restart = 1'b1;
      tick();
      bus.sync_restart = 1'b0;
      chk("restart_cen", int'(bus.cen), 0);
      p0 = 0; p1 = 0; mm = 0;
      repeat (21) begin
         tick();
         p0 += int'(bus.cen[0]);
         p1 += int'(bus.cen[1]);
         if (bus.cen[0] != bus.cen[1]) mm++;
      end
      chk("align_ch0_pulses", p0, 9);
      chk("align_ch1_pulses", p1, 9);
      chk("align_diff", mm, 0);

      // Lock loss in RUN.
      bus.pll_locked = 1'b0;
      tick(); tick();
      chk("loss_still_locked", int'(bus.locked), 1);
      tick();
      chk("loss_cen", int'(bus.cen), 0);
      chk("loss_rst_out", int'(bus.rst_out), 1);
      chk("loss_locked", int'(bus.locked), 0);
      chk("loss_flag", int'(bus.lock_lost), 1);

      bus.pll_locked = 1'b1;
      wait_lock(n);
      chk("relock_edges", n, 19);
      chk("relock_flag", int'(bus.lock_lost), 1);
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
      chk("clr_flag", int'(bus.lock_lost), 0);

      // Set and clear on the same edge: set wins.
      repeat (4) tick();
      bus.pll_locked = 1'b0;
      tick(); tick();
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
      chk("setwins_flag", int'(bus.lock_lost), 1);
      tick();
      chk("setwins_hold", int'(bus.lock_lost), 1);

      // Asynchronous reset mid-RUN.
      bus.pll_locked = 1'b1;
      wait_lock(n);
      repeat (5) tick();
      chk("pre_rst_ch2", int'(bus.cen[2]), 1);
      @(posedge refclk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_cen", int'(bus.cen), 0);
      chk("arst_rst_out", int'(bus.rst_out), 1);
      chk("arst_locked", int'(bus.locked), 0);
      chk("arst_lock_lost", int'(bus.lock_lost), 0);
      tick(); tick();
      rst = 1'b0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
